srdl2sv_b2r_initiator: RTL and testbench
========================================

Name: srdl2sv_b2r_initiator

Overview:
- Initiator-side counterpart of the register-block bus interface: turns a simple valid/ready command stream (debug master, firmware sequencer, test harness) into b2r_t transactions.
- Collects the register block's r2b_t reply and returns it on a valid/ready response stream.
- Exactly one transaction outstanding; a programmable timeout guarantees forward progress if the register block never asserts rdy.

Parameters:
- ADDR_W, 32, address width; must equal b2r_t.addr width
- DATA_W, 32, data width; must equal b2r_t.data width; multiple of 8
- TIMEOUT, 256, max cycles b2r valid is held without rdy before abort; 0 disables timeout

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- cmd_vld  input  1  command valid
- cmd_rdy  output  1  command accepted when cmd_vld&cmd_rdy
- cmd_we  input  1  1=write, 0=read
- cmd_addr  input  ADDR_W  register address
- cmd_wdata  input  DATA_W  write data
- cmd_be  input  DATA_W/8  byte enables
- b2r  output  b2r_t  request to register block (srdl2sv_if_pkg)
- r2b  input  r2b_t  reply from register block (srdl2sv_if_pkg)
- rsp_vld  output  1  response valid
- rsp_rdy  input  1  response consumed when rsp_vld&rsp_rdy
- rsp_rdata  output  DATA_W  read data; 0 for writes
- rsp_err  output  1  r2b.err captured, or timeout
- rsp_timeout  output  1  transaction aborted by timeout

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Register outputs: all b2r fields, rsp_* and state are registered.
- Reset values: cmd_rdy=1 (state IDLE); b2r all-zero (w_vld=r_vld=0); rsp_vld=0; rsp_rdata=0; rsp_err=0; rsp_timeout=0; timeout counter=0.
- State IDLE:
  - cmd_rdy=1.
  - On handshake at edge N, register addr/wdata/be into b2r and set w_vld=cmd_we, r_vld=!cmd_we.
  - Go to ACCESS.
  - b2r.data = cmd_wdata for writes, 0 for reads; byte_en passed through for both.
- State ACCESS (b2r valid high from cycle N+1):
  - cmd_rdy=0.
  - b2r fields are held stable until the cycle r2b.rdy is sampled high.
  - On r2b.rdy=1 at an edge:
    - Capture rsp_rdata = r2b.data on reads, 0 on writes; rsp_err = r2b.err; rsp_timeout=0.
    - Clear w_vld/r_vld at the same edge and set rsp_vld=1.
    - Go to RESP.
  - Zero-cycle register reply (rdy high in the first ACCESS cycle): rsp_vld is high in cycle N+2. Minimum command-to-command spacing is 3 cycles.
  - Timeout counter:
    - Increments each ACCESS cycle without rdy.
    - When TIMEOUT!=0 and the counter reaches TIMEOUT-1 with rdy still low, that edge aborts: clear vld, rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
    - If rdy and timeout coincide on the same edge, rdy wins (normal completion, timeout=0).
    - Counter clears on entry to ACCESS.
- State RESP:
  - rsp_vld=1, response fields held until rsp_rdy sampled.
  - Then rsp_vld=0, cmd_rdy=1, go to IDLE.
  - No bypass: a command presented during RESP waits.
- r2b.rdy/err/data are ignored outside ACCESS; rdy in IDLE/RESP has no effect.
- Reset mid-transaction (rst in ACCESS or RESP): next edge forces IDLE and reset values. The in-flight access is dropped with no response. The register block sees vld deassert after that edge.
- b2r.w_vld and b2r.r_vld are never both 1.

Test Plan:
- Write: cmd_we=1, addr=0x10, wdata=0xDEADBEEF, be=4'hF; r2b.rdy=1 in the first ACCESS cycle -> b2r.w_vld high exactly 1 cycle with those fields; rsp_vld at N+2, rsp_rdata=0, err=0, timeout=0.
- Read with wait states: addr=0x24; r2b.rdy asserted after 3 cycles with data=0x12345678 -> r_vld held 4 cycles, fields stable; rsp_rdata=0x12345678.
- Error: read with r2b.rdy=1, err=1 -> rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT=8, r2b.rdy never asserted -> r_vld high exactly 8 cycles, then rsp_vld with err=1, timeout=1, rdata=0. With TIMEOUT=0, vld is still held after 1000 cycles.
- Backpressure: rsp_rdy low 5 cycles with cmd_vld held high -> cmd_rdy=0 throughout, response stable; second command accepted the cycle after the rsp handshake.
- Reset mid-ACCESS: assert rst for 1 cycle while r_vld is high -> next cycle vld=0, rsp_vld=0, cmd_rdy=1; a late r2b.rdy produces no response.

Source files
------------

// File: rtl/srdl2sv_b2r_initiator.sv
// Initiator for the register-block bus: turns a valid/ready command stream into
// b2r_t requests and returns the r2b_t reply on a valid/ready response stream.

package srdl2sv_if_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] byte_en;
    logic                w_vld;
    logic                r_vld;
  } b2r_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              rdy;
    logic              err;
  } r2b_t;
endpackage

module srdl2sv_b2r_initiator
  import srdl2sv_if_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_vld,
  output logic                cmd_rdy,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_be,
  output b2r_t                b2r,
  input  r2b_t                r2b,
  output logic                rsp_vld,
  input  logic                rsp_rdy,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state_q, state_d;
  b2r_t               b2r_q, b2r_d;
  logic               rsp_vld_q, rsp_vld_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tmo_hit;

  // A zero TIMEOUT never matches, so the access waits for rdy indefinitely.
  assign tmo_hit = (TIMEOUT != 0) && (32'(cnt_q) == 32'(TIMEOUT - 1));

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d       = state_q;
    b2r_d         = b2r_q;
    rsp_vld_d     = rsp_vld_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_vld) begin
          b2r_d.addr    = cmd_addr;
          b2r_d.data    = cmd_we ? cmd_wdata : '0;
          b2r_d.byte_en = cmd_be;
          b2r_d.w_vld   = cmd_we;
          b2r_d.r_vld   = !cmd_we;
          cnt_d         = '0;
          state_d       = ACCESS;
        end
      end
      ACCESS: begin
        // rdy takes priority over a timeout expiring on the same edge.
        if (r2b.rdy) begin
          b2r_d.w_vld   = 1'b0;
          b2r_d.r_vld   = 1'b0;
          rsp_vld_d     = 1'b1;
          rsp_rdata_d   = b2r_q.r_vld ? r2b.data : '0;
          rsp_err_d     = r2b.err;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (tmo_hit) begin
          b2r_d.w_vld   = 1'b0;
          b2r_d.r_vld   = 1'b0;
          rsp_vld_d     = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_rdy) begin
          rsp_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      b2r_q         <= '0;
      rsp_vld_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      b2r_q         <= b2r_d;
      rsp_vld_q     <= rsp_vld_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_rdy     = (state_q == IDLE);
  assign b2r         = b2r_q;
  assign rsp_vld     = rsp_vld_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_srdl2sv_b2r_initiator.sv
// Self-checking bench: transaction-level model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic with resets.

module tb_srdl2sv_b2r_initiator;
  import srdl2sv_if_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_vld, cmd_rdy, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_be;
  b2r_t        b2r;
  r2b_t        r2b;
  logic        rsp_vld, rsp_rdy, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;

  // Second instance with the timeout disabled.
  logic        c0_vld, c0_rdy, rsp0_vld, rsp0_err, rsp0_to;
  logic [31:0] rsp0_rdata;
  b2r_t        b2r0;
  r2b_t        r2b0;

  int n_checks = 0;
  int n_errs   = 0;

  srdl2sv_b2r_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be), .b2r(b2r), .r2b(r2b),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout)
  );

  srdl2sv_b2r_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst), .cmd_vld(c0_vld), .cmd_rdy(c0_rdy), .cmd_we(1'b0),
    .cmd_addr(32'h80), .cmd_wdata(32'h0), .cmd_be(4'hF), .b2r(b2r0), .r2b(r2b0),
    .rsp_vld(rsp0_vld), .rsp_rdy(1'b0), .rsp_rdata(rsp0_rdata), .rsp_err(rsp0_err),
    .rsp_timeout(rsp0_to)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: at most one pending request, then one pending response.
  bit          m_known = 0;
  bit          m_req_v = 0, m_rsp_v = 0;
  bit          m_req_we;
  logic [31:0] m_req_addr, m_req_data;
  logic [3:0]  m_req_be;
  int          m_wait;
  logic [31:0] m_rsp_rdata;
  bit          m_rsp_err, m_rsp_to;

  always @(posedge clk) begin
    if (rst) begin
      m_known = 1;
      m_req_v = 0;
      m_rsp_v = 0;
      m_wait  = 0;
    end else if (m_rsp_v) begin
      if (rsp_rdy) m_rsp_v = 0;
    end else if (m_req_v) begin
      if (r2b.rdy) begin
        m_rsp_rdata = m_req_we ? 32'h0 : r2b.data;
        m_rsp_err   = r2b.err;
        m_rsp_to    = 0;
        m_req_v     = 0;
        m_rsp_v     = 1;
      end else if (TO != 0 && m_wait == TO - 1) begin
        m_rsp_rdata = 32'h0;
        m_rsp_err   = 1;
        m_rsp_to    = 1;
        m_req_v     = 0;
        m_rsp_v     = 1;
      end else begin
        m_wait++;
      end
    end else if (cmd_vld) begin
      m_req_we   = cmd_we;
      m_req_addr = cmd_addr;
      m_req_data = cmd_we ? cmd_wdata : 32'h0;
      m_req_be   = cmd_be;
      m_req_v    = 1;
      m_wait     = 0;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("m_cmd_rdy", cmd_rdy, !m_req_v && !m_rsp_v);
      check("m_w_vld", b2r.w_vld, m_req_v && m_req_we);
      check("m_r_vld", b2r.r_vld, m_req_v && !m_req_we);
      check("m_rsp_vld", rsp_vld, m_rsp_v);
      if (m_req_v) begin
        check("m_addr", b2r.addr, m_req_addr);
        check("m_data", b2r.data, m_req_data);
        check("m_be", b2r.byte_en, m_req_be);
      end
      if (m_rsp_v) begin
        check("m_rdata", rsp_rdata, m_rsp_rdata);
        check("m_err", rsp_err, m_rsp_err);
        check("m_timeout", rsp_timeout, m_rsp_to);
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_be    = be;
    cmd_vld   = 1'b1;
    step();
    cmd_vld   = 1'b0;
  endtask

  task automatic consume();
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;
  endtask

  initial begin
    int n;
    cmd_vld = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_be = 0;
    r2b = '0; rsp_rdy = 0; c0_vld = 0; r2b0 = '0;
    repeat (2) step();
    @(negedge clk);
    check("rst_cmd_rdy", cmd_rdy, 1'b1);
    check("rst_b2r", b2r, '0);
    check("rst_rsp_vld", rsp_vld, 1'b0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err_to", {rsp_err, rsp_timeout}, 2'b00);
    step();
    rst = 1'b0;
    step();

    // Write with zero-cycle reply; rdy in IDLE must be ignored.
    r2b.rdy = 1'b1;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    check("wr_w_vld", b2r.w_vld, 1'b1);
    check("wr_fields", {b2r.addr, b2r.data}, {32'h10, 32'hDEADBEEF});
    check("wr_be", b2r.byte_en, 4'hF);
    check("wr_rsp_early", rsp_vld, 1'b0);
    step();
    r2b.rdy = 1'b0;
    @(negedge clk);
    check("wr_w_vld_off", b2r.w_vld, 1'b0);
    check("wr_rsp_vld", rsp_vld, 1'b1);
    check("wr_rsp", {rsp_rdata, rsp_err, rsp_timeout}, {32'h0, 2'b00});
    consume();
    @(negedge clk);
    check("wr_cmd_rdy_back", cmd_rdy, 1'b1);

    // Read with three wait states.
    issue(1'b0, 32'h24, 32'hFFFFFFFF, 4'hF);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      n += int'(b2r.r_vld);
      check("rd_stable", {b2r.addr, b2r.data}, {32'h24, 32'h0});
      step();
    end
    r2b.rdy = 1'b1; r2b.data = 32'h12345678;
    @(negedge clk);
    n += int'(b2r.r_vld);
    step();
    r2b = '0;
    @(negedge clk);
    check("rd_vld_cycles", n, 4);
    check("rd_r_vld_off", b2r.r_vld, 1'b0);
    check("rd_rdata", rsp_rdata, 32'h12345678);
    consume();

    // Error reply.
    r2b.rdy = 1'b1; r2b.err = 1'b1; r2b.data = 32'h0000A5A5;
    issue(1'b0, 32'h30, 32'h0, 4'h3);
    step();
    r2b = '0;
    @(negedge clk);
    check("err_rsp", {rsp_vld, rsp_err, rsp_timeout}, 3'b110);
    consume();

    // Timeout after exactly TO cycles.
    issue(1'b0, 32'h40, 32'h0, 4'hF);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      n += int'(b2r.r_vld);
      step();
    end
    @(negedge clk);
    check("to_vld_cycles", n, 8);
    check("to_rsp", {rsp_vld, rsp_err, rsp_timeout}, 3'b111);
    check("to_rdata", rsp_rdata, 32'h0);
    consume();

    // Response backpressure with the next command already waiting.
    r2b.rdy = 1'b1;
    issue(1'b1, 32'h50, 32'h11111111, 4'hF);
    cmd_vld = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h60;
    step();
    r2b.rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_cmd_rdy", cmd_rdy, 1'b0);
      check("bp_rsp", {rsp_vld, rsp_rdata, rsp_err}, {1'b1, 32'h0, 1'b0});
      step();
    end
    consume();
    @(negedge clk);
    check("bp_cmd_rdy_after", cmd_rdy, 1'b1);
    step();
    cmd_vld = 1'b0;
    @(negedge clk);
    check("bp_second", {b2r.r_vld, b2r.addr}, {1'b1, 32'h60});
    r2b.rdy = 1'b1; r2b.data = 32'h77;
    step();
    r2b = '0;
    consume();

    // Reset in the middle of an access drops it.
    issue(1'b0, 32'h70, 32'h0, 4'hF);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst", {b2r.r_vld, rsp_vld, cmd_rdy}, 3'b001);
    r2b.rdy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_late_rdy", rsp_vld, 1'b0);
      step();
    end
    r2b = '0;

    // Randomized traffic against the model.
    repeat (3000) begin
      cmd_vld   = ($urandom_range(0, 2) != 0);
      cmd_we    = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_be    = 4'($urandom);
      r2b.rdy   = ($urandom_range(0, 4) == 0);
      r2b.err   = 1'($urandom);
      r2b.data  = $urandom;
      rsp_rdy   = 1'($urandom);
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; cmd_vld = 1'b0; r2b.rdy = 1'b1; rsp_rdy = 1'b1;
    repeat (5) step();

    // Disabled timeout: the access is still pending after 1000 cycles.
    c0_vld = 1'b1;
    step();
    c0_vld = 1'b0;
    repeat (1000) step();
    @(negedge clk);
    check("no_to_held", {b2r0.r_vld, rsp0_vld, c0_rdy}, 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
